// File: rtl/wmem_pkg.sv
// Shared types and sizing helpers for the weight memory streaming block.
package wmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROW_NUM_DEF    = 6;
    localparam int ADDR_WIDTH_DEF = 7;
    localparam int DEPTH_DEF      = 128;

    function automatic int row_wgt_width(input int data_width, input int row_num);
        return data_width * row_num;
    endfunction

    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/wmem_sram_1r1w.sv
// One-write/one-read row storage with a registered read port; a collision
// returns the old row. Kept self-contained so a foundry macro can replace it.
module wmem_sram_1r1w #(
    parameter int WIDTH      = 48,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is cleared; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/wmem_stream.sv
// Weight memory with bias register and a burst-read engine that streams
// consecutive rows over valid/ready, wrapping at the end of the array.
module wmem_stream
    import wmem_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ROW_NUM       = ROW_NUM_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int ROW_WGT_WIDTH = row_wgt_width(DATA_WIDTH, ROW_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic                     i_wr_bias,
    input  logic [ADDR_WIDTH-1:0]    i_wr_addr,
    input  logic [ROW_WGT_WIDTH-1:0] i_wr_data,
    input  logic                     i_start,
    input  logic [ADDR_WIDTH-1:0]    i_start_addr,
    input  logic [ADDR_WIDTH:0]      i_len,
    input  logic                     i_rd_ready,
    output logic                     o_rd_valid,
    output logic [ROW_WGT_WIDTH-1:0] o_rd_data,
    output logic                     o_rd_last,
    output logic [ROW_WGT_WIDTH-1:0] o_bias,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int LEN_WIDTH = len_width(ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);

    state_e                   state_q;
    logic [ADDR_WIDTH-1:0]    ptr_q;
    logic [ADDR_WIDTH-1:0]    ptr_d;
    logic [LEN_WIDTH-1:0]     rem_q;
    logic                     valid_q;
    logic                     last_q;
    logic                     busy_q;
    logic                     done_q;
    logic [ROW_WGT_WIDTH-1:0] bias_q;
    logic [ADDR_WIDTH-1:0]    start_ptr;
    logic                     issue;
    logic                     mem_we;

    assign issue     = (state_q == ST_RUN) && (!valid_q || i_rd_ready);
    assign ptr_d     = (ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
    assign start_ptr = ADDR_WIDTH'({1'b0, i_start_addr} % DEPTH_L);
    assign mem_we    = i_wr_en && !i_wr_bias && ({1'b0, i_wr_addr} < DEPTH_L);

    // The RAM read register doubles as the beat data register, so it is
    // only advanced on issue and therefore holds while stalled.
    wmem_sram_1r1w #(
        .WIDTH      (ROW_WGT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (mem_we),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_re    (issue),
        .i_raddr (ptr_q),
        .o_rdata (o_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bias_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (i_wr_en && i_wr_bias) begin
                bias_q <= i_wr_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            ptr_q   <= start_ptr;
                            rem_q   <= i_len;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        valid_q <= 1'b1;
                        ptr_q   <= ptr_d;
                        rem_q   <= rem_q - LEN_WIDTH'(1);
                        last_q  <= (rem_q == LEN_WIDTH'(1));
                        if (rem_q == LEN_WIDTH'(1)) begin
                            state_q <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    if (valid_q && i_rd_ready && last_q) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_valid = valid_q;
    assign o_rd_last  = last_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_bias     = bias_q;

endmodule

// File: tb/tb_wmem_stream.sv
// Self-checking bench for wmem_stream: directed burst table, corner sequences
// and randomized bursts checked against a row-array model.
module tb_wmem_stream;

    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int RW    = 48;
    localparam logic [RW-1:0] COLLIDE_D = 48'hDEAD_BEEF_0003;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_wr_en = 1'b0;
    logic          i_wr_bias = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [RW-1:0] i_wr_data = '0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_start_addr = '0;
    logic [AW:0]   i_len = '0;
    logic          i_rd_ready = 1'b0;
    logic          o_rd_valid;
    logic [RW-1:0] o_rd_data;
    logic          o_rd_last;
    logic [RW-1:0] o_bias;
    logic          o_busy;
    logic          o_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    wmem_stream dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_wr_en      (i_wr_en),
        .i_wr_bias    (i_wr_bias),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_start      (i_start),
        .i_start_addr (i_start_addr),
        .i_len        (i_len),
        .i_rd_ready   (i_rd_ready),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_rd_last    (o_rd_last),
        .o_bias       (o_bias),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW:0]   ln;
        int            mode;     // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        bit            poke;     // issue a start while busy
        bit            collide;  // write row 3 at the edge it is read
        int            exp_beats;
        logic [RW-1:0] exp_last;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [RW-1:0] pat(input int r);
        return {40'hA55A3CC35F, 8'(r)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input bit b, input logic [AW-1:0] a, input logic [RW-1:0] d);
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_bias = b; i_wr_addr = a; i_wr_data = d;
        @(negedge clk);
        i_wr_en = 1'b0; i_wr_bias = 1'b0;
        if (b) check("bias_write", o_bias, d);
        else   mem_m[a] = d;
    endtask

    task automatic run_burst(input logic [AW-1:0] sa, input logic [AW:0] ln, input int mode,
                             input bit poke, input bit collide,
                             output int beats, output logic [RW-1:0] last_data);
        logic [RW-1:0] expq [$];
        logic [RW-1:0] exp_d;
        logic [RW-1:0] held;
        bit stalled, rdy, v, finished;
        int done_cnt, done_cyc, first_hs, last_hs, valid_seen;
        stalled = 0; finished = 0; held = '0;
        done_cnt = 0; done_cyc = -1; first_hs = -1; last_hs = -1; valid_seen = 0;
        beats = 0; last_data = '0;
        for (int k = 0; k < int'(ln); k++) expq.push_back(mem_m[(int'(sa) + k) % DEPTH]);
        @(negedge clk);
        i_start = 1'b1; i_start_addr = sa; i_len = ln; i_rd_ready = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                i_start = 1'b0;
                check("first_cycle_valid", 64'(o_rd_valid), 0);
            end
            if (poke && cyc == 3) begin
                i_start = 1'b1; i_start_addr = '0; i_len = 8'd5;
            end
            if (poke && cyc == 4) i_start = 1'b0;
            if (collide && cyc == 1) begin
                i_wr_en = 1'b1; i_wr_bias = 1'b0; i_wr_addr = 7'd3; i_wr_data = COLLIDE_D;
            end
            if (collide && cyc == 2) begin
                i_wr_en = 1'b0;
                mem_m[3] = COLLIDE_D;
            end
            v = o_rd_valid;
            if (stalled) begin
                check("stall_valid", 64'(o_rd_valid), 1);
                check("stall_hold", o_rd_data, held);
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (v) valid_seen++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_rd_ready = rdy;
            if (v && rdy) begin
                beats++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (expq.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    exp_d = expq.pop_front();
                    check("beat_data", o_rd_data, exp_d);
                    check("beat_last", 64'(o_rd_last), 64'(expq.size() == 0));
                    if (expq.size() == 0) last_data = o_rd_data;
                end
            end
            stalled = v && !rdy;
            held = o_rd_data;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                finished = 1;
                break;
            end
        end
        i_rd_ready = 1'b0;
        if (!finished) check("burst_timeout", 0, 1);
        check("beat_count", 64'(beats), 64'(ln));
        check("done_pulses", 64'(done_cnt), 1);
        check("busy_after", 64'(o_busy), 0);
        if (ln == 0) begin
            check("len0_no_valid", 64'(valid_seen), 0);
            check("len0_done_cycle", 64'(done_cyc), 0);
        end else begin
            check("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
        end
        if (mode == 0 && ln != 0) begin
            check("first_beat_latency", 64'(first_hs), 1);
            check("throughput", 64'(last_hs - first_hs), 64'(int'(ln) - 1));
        end
        $display("burst sa=%0d len=%0d mode=%0d beats=%0d", sa, ln, mode, beats);
    endtask

    initial begin
        int beats, hs, rn;
        logic [RW-1:0] last_data, d;
        logic [AW-1:0] sa;
        logic [AW:0]   ln;

        vecs[0] = '{7'd2,   8'd4,   0, 1'b0, 1'b0, 4,   pat(5)};
        vecs[1] = '{7'd2,   8'd4,   1, 1'b0, 1'b0, 4,   pat(5)};
        vecs[2] = '{7'd126, 8'd4,   0, 1'b0, 1'b0, 4,   pat(1)};
        vecs[3] = '{7'd126, 8'd4,   2, 1'b0, 1'b0, 4,   pat(1)};
        vecs[4] = '{7'd0,   8'd0,   0, 1'b0, 1'b0, 0,   '0};
        vecs[5] = '{7'd40,  8'd10,  0, 1'b1, 1'b0, 10,  pat(49)};
        vecs[6] = '{7'd2,   8'd4,   0, 1'b0, 1'b1, 4,   pat(5)};
        vecs[7] = '{7'd3,   8'd1,   0, 1'b0, 1'b0, 1,   COLLIDE_D};
        vecs[8] = '{7'd5,   8'd128, 2, 1'b0, 1'b0, 128, pat(4)};
        vecs[9] = '{7'd127, 8'd1,   1, 1'b0, 1'b0, 1,   pat(127)};

        // Reset state
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(o_rd_valid), 0);
        check("rst_last",  64'(o_rd_last), 0);
        check("rst_busy",  64'(o_busy), 0);
        check("rst_done",  64'(o_done), 0);
        check("rst_bias",  o_bias, 0);
        check("rst_data",  o_rd_data, 0);
        i_rst_n = 1'b1;

        for (int r = 0; r < DEPTH; r++) do_write(1'b0, 7'(r), pat(r));
        // Bias write carries a row address that must not disturb row 5
        do_write(1'b1, 7'd5, 48'h0102_0304_0506);

        for (int i = 0; i < 10; i++) begin
            run_burst(vecs[i].sa, vecs[i].ln, vecs[i].mode, vecs[i].poke, vecs[i].collide,
                      beats, last_data);
            check("vec_beats", 64'(beats), 64'(vecs[i].exp_beats));
            if (vecs[i].exp_beats > 0) check("vec_last_data", last_data, vecs[i].exp_last);
        end

        // Reset after two beats of a six-row burst
        @(negedge clk);
        i_start = 1'b1; i_start_addr = 7'd10; i_len = 8'd6; i_rd_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        hs = 0;
        for (int cyc = 0; cyc < 20 && hs < 2; cyc++) begin
            @(negedge clk);
            if (o_rd_valid) begin
                check("abort_beat_data", o_rd_data, pat(10 + hs));
                hs++;
            end
        end
        check("abort_beats_before", 64'(hs), 2);
        i_rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(o_rd_valid), 0);
        check("abort_busy",  64'(o_busy), 0);
        check("abort_done",  64'(o_done), 0);
        check("abort_data",  o_rd_data, 0);
        check("abort_bias",  o_bias, 0);
        i_rst_n = 1'b1;
        i_rd_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("abort_no_done", 64'(o_done), 0);
        end
        run_burst(7'd20, 8'd3, 0, 1'b0, 1'b0, beats, last_data);
        check("post_abort_last", last_data, pat(22));

        // Randomized writes and bursts against the row model
        for (int t = 0; t < 20; t++) begin
            rn = $urandom_range(0, 6);
            for (int w = 0; w < rn; w++) begin
                d = {$urandom(), 16'($urandom())};
                do_write(1'b0, 7'($urandom_range(0, DEPTH - 1)), d);
            end
            d = {$urandom(), 16'($urandom())};
            do_write(1'b1, 7'($urandom_range(0, DEPTH - 1)), d);
            sa = 7'($urandom_range(0, DEPTH - 1));
            ln = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, DEPTH))
                                             : 8'($urandom_range(0, 12));
            run_burst(sa, ln, 2, 1'b0, 1'b0, beats, last_data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
